// File: rtl/iq_nco_pkg.sv
// Shared widths, types and helpers for the I/Q NCO upconverter.
// The quarter-wave sine table is generated at elaboration time by quarter_sine().
package iq_nco_pkg;

   localparam int DATA_W      = 16;
   localparam int PHASE_W     = 24;
   localparam int LUT_AW      = 10;
   localparam int QUARTER_LEN = 256;
   localparam int PROD_W      = 2 * DATA_W;
   localparam int SUM_W       = 2 * DATA_W + 1;

   typedef logic signed [DATA_W-1:0]  sample_t;
   typedef logic        [PHASE_W-1:0] phase_t;
   typedef logic signed [PROD_W-1:0]  product_t;
   typedef logic signed [SUM_W-1:0]   sum_t;

   localparam sample_t SAT_MAX    = 16'sh7FFF;
   localparam sample_t SAT_MIN    = 16'sh8000;
   localparam sum_t    ROUND_BIAS = 33'sd16384;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   localparam real PI = 3.14159265358979;

   // round(32767 * sin(2*pi*k/1024)) for k in 0..256, via a Taylor series
   // so that only basic real arithmetic is needed at elaboration.
   function automatic logic [DATA_W-2:0] quarter_sine(input int k);
      real x;
      real term;
      real acc;
      int  value;
      x    = 2.0 * PI * $itor(k) / 1024.0;
      term = x;
      acc  = x;
      for (int n = 1; n < 12; n++) begin
         term = -term * x * x / $itor((2 * n) * (2 * n + 1));
         acc  = acc + term;
      end
      value = $rtoi(acc * 32767.0 + 0.5);
      return value[DATA_W-2:0];
   endfunction

   // Q2.30 sum to Q1.15: round half-up, arithmetic shift, saturate.
   function automatic sample_t round_sat(input sum_t sum);
      sum_t    shifted;
      sample_t result;
      shifted = (sum + ROUND_BIAS) >>> (DATA_W - 1);
      if (shifted > sum_t'(SAT_MAX)) begin
         result = SAT_MAX;
      end else if (shifted < sum_t'(SAT_MIN)) begin
         result = SAT_MIN;
      end else begin
         result = shifted[DATA_W-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/nco_sincos_lut.sv
// Quarter-wave sine/cosine lookup with registered outputs (1-cycle latency).
// Mirrors the 257-entry table by quadrant and negates in the lower half-plane.
module nco_sincos_lut
   import iq_nco_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [LUT_AW-1:0] phase,
   output logic [DATA_W-1:0] sin_out,
   output logic [DATA_W-1:0] cos_out
);

   logic [DATA_W-2:0] rom_s [0:QUARTER_LEN];

   for (genvar k = 0; k <= QUARTER_LEN; k++) begin : g_rom
      localparam logic [DATA_W-2:0] ENTRY = quarter_sine(k);
      assign rom_s[k] = ENTRY;
   end

   logic [LUT_AW-1:0] cos_phase_s;
   logic [8:0]        sin_idx_s;
   logic [8:0]        cos_idx_s;
   sample_t           sin_val_s;
   sample_t           cos_val_s;

   // Quadrant folding: odd quadrants read the table backwards, upper half negates.
   always_comb begin
      cos_phase_s = phase + 10'd256;
      if (phase[8]) begin
         sin_idx_s = 9'd256 - {1'b0, phase[7:0]};
      end else begin
         sin_idx_s = {1'b0, phase[7:0]};
      end
      if (cos_phase_s[8]) begin
         cos_idx_s = 9'd256 - {1'b0, cos_phase_s[7:0]};
      end else begin
         cos_idx_s = {1'b0, cos_phase_s[7:0]};
      end
      if (phase[9]) begin
         sin_val_s = -sample_t'({1'b0, rom_s[sin_idx_s]});
      end else begin
         sin_val_s = sample_t'({1'b0, rom_s[sin_idx_s]});
      end
      if (cos_phase_s[9]) begin
         cos_val_s = -sample_t'({1'b0, rom_s[cos_idx_s]});
      end else begin
         cos_val_s = sample_t'({1'b0, rom_s[cos_idx_s]});
      end
   end

   // Register the looked-up pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sin_out <= '0;
         cos_out <= '0;
      end else begin
         sin_out <= sin_val_s;
         cos_out <= cos_val_s;
      end
   end

endmodule

// File: rtl/iq_nco_upconverter.sv
// Complex NCO mixer: y = (I + jQ) * e^(j*phase), four-stage pipeline.
// Optional phase dither: define IQ_NCO_PHASE_DITHER_EN to add LFSR bits
// below the lookup slice before truncation.
module iq_nco_upconverter
   import iq_nco_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  real_in,
   input  logic [DATA_W-1:0]  imag_in,
   input  logic               freq_load,
   input  logic [PHASE_W-1:0] freq_word,
   input  logic               phase_clr,
   output logic               out_valid,
   output logic [DATA_W-1:0]  real_out,
   output logic [DATA_W-1:0]  imag_out
);

   phase_t            phase_r;
   phase_t            word_r;
   logic [LUT_AW-1:0] lut_phase_s;
   logic [LUT_AW-1:0] p1_r;
   logic              valid1_r;
   logic              valid2_r;
   logic              valid3_r;
   sample_t           real1_r;
   sample_t           imag1_r;
   sample_t           real2_r;
   sample_t           imag2_r;
   sample_t           sin_s;
   sample_t           cos_s;
   product_t          ic_r;
   product_t          qs_r;
   product_t          is_r;
   product_t          qc_r;
   sum_t              re_sum_s;
   sum_t              im_sum_s;

`ifdef IQ_NCO_PHASE_DITHER_EN
   logic [15:0] lfsr_r;
   logic        lfsr_fb_s;
   phase_t      dith_phase_s;

   assign lfsr_fb_s    = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
   assign dith_phase_s = phase_r + phase_t'(lfsr_r[PHASE_W-LUT_AW-1:0]);
   assign lut_phase_s  = dith_phase_s[PHASE_W-1 -: LUT_AW];

   // Dither source advances once per accepted sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r <= LFSR_SEED;
      end else if (in_valid) begin
         lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
      end
   end
`else
   assign lut_phase_s = phase_r[PHASE_W-1 -: LUT_AW];
`endif

   // Frequency word latch and phase accumulator; clear beats increment,
   // and the current sample always sees the pre-update phase and word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_r <= '0;
         word_r  <= '0;
      end else begin
         if (freq_load) begin
            word_r <= freq_word;
         end
         if (phase_clr) begin
            phase_r <= '0;
         end else if (in_valid) begin
            phase_r <= phase_r + word_r;
         end
      end
   end

   // S1: capture lookup phase and input pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid1_r <= 1'b0;
         p1_r     <= '0;
         real1_r  <= '0;
         imag1_r  <= '0;
      end else begin
         valid1_r <= in_valid;
         if (in_valid) begin
            p1_r    <= lut_phase_s;
            real1_r <= real_in;
            imag1_r <= imag_in;
         end
      end
   end

   nco_sincos_lut u_lut (
      .clk     (clk),
      .rst_n   (rst_n),
      .phase   (p1_r),
      .sin_out (sin_s),
      .cos_out (cos_s)
   );

   // S2: delay the data alongside the table read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid2_r <= 1'b0;
         real2_r  <= '0;
         imag2_r  <= '0;
      end else begin
         valid2_r <= valid1_r;
         real2_r  <= real1_r;
         imag2_r  <= imag1_r;
      end
   end

   // S3: the four cross products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid3_r <= 1'b0;
         ic_r     <= '0;
         qs_r     <= '0;
         is_r     <= '0;
         qc_r     <= '0;
      end else begin
         valid3_r <= valid2_r;
         ic_r     <= product_t'(real2_r) * product_t'(cos_s);
         qs_r     <= product_t'(imag2_r) * product_t'(sin_s);
         is_r     <= product_t'(real2_r) * product_t'(sin_s);
         qc_r     <= product_t'(imag2_r) * product_t'(cos_s);
      end
   end

   // Full-precision complex sums ahead of rounding.
   always_comb begin
      re_sum_s = sum_t'(ic_r) - sum_t'(qs_r);
      im_sum_s = sum_t'(is_r) + sum_t'(qc_r);
   end

   // S4: rounded, saturated outputs; data holds between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         real_out  <= '0;
         imag_out  <= '0;
      end else begin
         out_valid <= valid3_r;
         if (valid3_r) begin
            real_out <= round_sat(re_sum_s);
            imag_out <= round_sat(im_sum_s);
         end
      end
   end

endmodule

// File: tb/tb_iq_nco_upconverter.sv
// Scoreboard bench for iq_nco_upconverter: stimulus pushes hand-computed
// results, a negedge monitor pops and compares on each out_valid.
module tb_iq_nco_upconverter;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic signed [15:0] real_in;
   logic signed [15:0] imag_in;
   logic               freq_load;
   logic [23:0]        freq_word;
   logic               phase_clr;
   logic               out_valid;
   logic signed [15:0] real_out;
   logic signed [15:0] imag_out;

   typedef struct {
      logic signed [15:0] re;
      logic signed [15:0] im;
      int                 cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   iq_nco_upconverter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .real_in   (real_in),
      .imag_in   (imag_in),
      .freq_load (freq_load),
      .freq_word (freq_word),
      .phase_clr (phase_clr),
      .out_valid (out_valid),
      .real_out  (real_out),
      .imag_out  (imag_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, act, req);
      end
   endtask

   task automatic expect_out(input logic signed [15:0] re, input logic signed [15:0] im);
      sb.push_back('{re: re, im: im, cyc: cyc + 4});
   endtask

   // one clock of stimulus, starting and ending 1 time unit after posedge
   task automatic step(input logic v, input logic signed [15:0] i, input logic signed [15:0] q,
                       input logic ld, input logic [23:0] w, input logic clr);
      in_valid  = v;
      real_in   = v ? i : 16'($urandom);
      imag_in   = v ? q : 16'($urandom);
      freq_load = ld;
      freq_word = w;
      phase_clr = clr;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      freq_load = 1'b0;
      phase_clr = 1'b0;
      freq_word = 24'($urandom);
      real_in   = 16'($urandom);
      imag_in   = 16'($urandom);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 16'sd0, 16'sd0, 1'b0, 24'($urandom), 1'b0);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s outstanding=%0d required 0", name, sb.size());
      end
   endtask

   // monitor: pop on each strobe, otherwise outputs must hold
   initial begin : monitor
      exp_t               e;
      logic signed [15:0] hold_re;
      logic signed [15:0] hold_im;
      hold_re = 16'sd0;
      hold_im = 16'sd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_re = 16'sd0;
            hold_im = 16'sd0;
         end else if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out_valid cyc=%0d real_out=%0d imag_out=%0d required no strobe",
                        cyc, real_out, imag_out);
            end else begin
               e = sb.pop_front();
               if (real_out !== e.re || imag_out !== e.im || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL sample got (%0d,%0d) at cyc %0d required (%0d,%0d) at cyc %0d",
                           real_out, imag_out, cyc, e.re, e.im, e.cyc);
               end
               hold_re = e.re;
               hold_im = e.im;
            end
         end else begin
            checks++;
            if (out_valid !== 1'b0 || real_out !== hold_re || imag_out !== hold_im) begin
               errors++;
               $display("FAIL hold cyc=%0d got v=%b (%0d,%0d) required v=0 (%0d,%0d)",
                        cyc, out_valid, real_out, imag_out, hold_re, hold_im);
            end
         end
      end
   end

   initial begin : stimulus
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      real_in   = 16'sd0;
      imag_in   = 16'sd0;
      freq_load = 1'b0;
      freq_word = 24'd0;
      phase_clr = 1'b0;
      #2 rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'sd0);
      chk("reset_real_out", real_out, 32'sd0);
      chk("reset_imag_out", imag_out, 32'sd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(3);

      // zero frequency, phase 0: cos = 32767
      expect_out(16'sd16384, 16'sd0);
      step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b0);
      idle(5);

      // quarter-turn word; four samples walk 0,90,180,270 and wrap to 0
      step(1'b0, 16'sd0, 16'sd0, 1'b1, 24'h400000, 1'b0);
      expect_out(16'sd16384, 16'sd0);      step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b0);
      expect_out(16'sd0, 16'sd16384);      step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b0);
      expect_out(-16'sd16383, 16'sd0);     step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b0);
      expect_out(16'sd0, -16'sd16383);     step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b0);
      // wrapped to 0 again; clear lands on the 270 sample
      expect_out(16'sd16384, 16'sd0);      step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b0);
      expect_out(16'sd0, 16'sd16384);      step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b0);
      expect_out(-16'sd16383, 16'sd0);     step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b0);
      expect_out(16'sd0, -16'sd16383);     step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b1);
      expect_out(16'sd16384, 16'sd0);      step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b0);
      idle(2);

      // eighth-turn word from phase 0, full-scale negative inputs, saturation at 45 deg
      step(1'b0, 16'sd0, 16'sd0, 1'b1, 24'h200000, 1'b1);
      expect_out(-16'sd32767, -16'sd32767); step(1'b1, -16'sd32768, -16'sd32768, 1'b0, 24'd0, 1'b0);
      expect_out(16'sd0, -16'sd32768);      step(1'b1, -16'sd32768, -16'sd32768, 1'b0, 24'd0, 1'b0);
      idle(1);

      // load with valid: phase 90 -> 135 (old word) -> 225 (new word)
      expect_out(16'sd0, 16'sd16384);       step(1'b1, 16'sd16384, 16'sd0, 1'b1, 24'h400000, 1'b0);
      expect_out(-16'sd11585, 16'sd11585);  step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b0);
      expect_out(-16'sd11585, -16'sd11585); step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b0);
      drain("drain_before_reset");

      // three samples in flight, then asynchronous reset mid-cycle
      step(1'b1, 16'sd1000, 16'sd2000, 1'b0, 24'd0, 1'b0);
      step(1'b1, 16'sd3000, 16'sd4000, 1'b0, 24'd0, 1'b0);
      step(1'b1, 16'sd5000, 16'sd6000, 1'b0, 24'd0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_out_valid", 32'(out_valid), 32'sd0);
      chk("async_reset_real_out", real_out, 32'sd0);
      chk("async_reset_imag_out", imag_out, 32'sd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(8);

      // phase and word back at zero after reset
      expect_out(16'sd16384, 16'sd0);  step(1'b1, 16'sd16384, 16'sd0, 1'b0, 24'd0, 1'b0);
      expect_out(16'sd0, 16'sd16384);  step(1'b1, 16'sd0, 16'sd16384, 1'b0, 24'd0, 1'b0);
      drain("drain_final");
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iq_nco_upconverter.md
Name: iq_nco_upconverter

Overview:
- Downstream of the x10 CIC interpolator. Consumes the 16-bit I/Q pair produced at the interpolated rate.
- Mixes the pair with a numerically controlled oscillator: y = (I + jQ)·e^(jφ).
- Delivers the upconverted complex sample to the DAC/IF path.
- Fully pipelined and strobe-driven; one sample per in_valid; no backpressure.

Parameters:
- DATA_W, 16, I/Q input and output width, signed Q1.15.
- PHASE_W, 24, phase accumulator and frequency word width.
- LUT_AW, 10, phase bits used for lookup: 2 quadrant bits + 8 address bits.

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  sample strobe, one cycle per sample
- real_in  in  DATA_W  I sample
- imag_in  in  DATA_W  Q sample
- freq_load  in  1  latch freq_word
- freq_word  in  PHASE_W  phase increment per sample (unsigned)
- phase_clr  in  1  synchronous clear of the phase accumulator
- out_valid  out  1  output strobe
- real_out  out  DATA_W  I·cos − Q·sin
- imag_out  out  DATA_W  I·sin + Q·cos

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: phase=0, active word=0, pipeline valids=0, out_valid=0, real_out=0, imag_out=0.
- Reset asserted mid-operation flushes all in-flight samples; no out_valid is produced for them.
- Phase accumulator:
  - Sample n uses the accumulator value before its update.
  - On in_valid: phase <= phase + active_word (mod 2^PHASE_W, wraps silently).
- freq_load: active_word <= freq_word at the clock edge.
  - If in_valid occurs in the same cycle, that sample's increment uses the old word.
- phase_clr: phase <= 0 at the clock edge; it has priority over the in_valid increment.
  - The sample in the same cycle still uses the pre-clear phase.
- Lookup:
  - p = phase[PHASE_W-1 -: LUT_AW]; quadrant q = p[9:8]; a = p[7:0].
  - Table T[k] = round(32767·sin(2πk/1024)), k = 0..256 (257 entries).
  - sin by quadrant: q0 T[a]; q1 T[256−a]; q2 −T[a]; q3 −T[256−a].
  - cos(p) = sin(p + 256 mod 1024).
- Arithmetic:
  - Four signed 16×16 products (Q2.30).
  - Sums are 33-bit.
  - Round half-up: add 2^14, then arithmetic shift right by 15.
  - Saturate to [−32768, 32767].
- Pipeline, fixed latency 4 cycles:
  - S1 registers phase slice and input data.
  - S2 registers the LUT read.
  - S3 registers the products.
  - S4 registers the rounded, saturated outputs.
- Timing: in_valid at cycle t → out_valid high for exactly one cycle at t+4.
- Back-to-back in_valid every cycle is supported.
- real_out and imag_out hold their value between out_valid pulses.
- Data inputs are ignored when in_valid=0.

Optional Feature:
- Macro IQ_NCO_PHASE_DITHER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1; reset to seed) advances on each in_valid.
  - Its low (PHASE_W−LUT_AW) bits are added to the phase before truncation; the accumulator itself is unaffected.
  - Latency is unchanged.
- When undefined: the phase is truncated with no dither, and no LFSR logic exists.

Decomposition:
- Package iq_nco_pkg holds:
  - Widths: DATA_W, PHASE_W, LUT_AW.
  - QUARTER_LEN=256.
  - SAT_MAX/SAT_MIN constants.
  - Signed sample and phase typedefs.
  - The table-generation function.
- Sub-module nco_sincos_lut:
  - Input: LUT_AW-bit phase.
  - Outputs: registered sin/cos, 1-cycle latency.
  - Contains quarter-wave mirroring and negation.

Test Plan:
- Reset then freq_word=0, in_valid with I=16384, Q=0 → 4 cycles later out_valid=1, real_out=16384, imag_out=0. Outputs are 0 during and after reset until that point.
- freq_load with freq_word=0x400000 (quarter turn), four valids with I=16384, Q=0:
  - real_out = 16384, 0, −16383, 0
  - imag_out = 0, 16384, 0, −16383
- freq_word=0x200000, two valids with I=Q=−32768 → second output real_out=0, imag_out=−32768 (saturated from −46340).
- phase_clr asserted mid-stream at phase 270° with freq_word=0x400000:
  - The same-cycle sample uses 270°.
  - The next sample uses 0° (real_out=16384 for I=16384, Q=0).
- freq_load and in_valid in the same cycle → that sample's increment uses the old word; the following increment uses the new word.
- rst_n asserted asynchronously with 3 samples in flight → out_valid and outputs go to 0 immediately; no out_valid after release until a new in_valid +4.
